// File: rtl/timer_cfg_seq.sv
// Bus-side sequencer for the 16-bit timer. It programs cnt, prd and con in order,
// acknowledges interrupt events, and disables the timer on count, timeout or stop.
module timer_cfg_seq #(
  parameter int WR_GAP      = 2,
  parameter int TMO_W       = 20,
  parameter int INT_CLR_BIT = 15
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             stop,
  input  logic [15:0]      cfg_cnt,
  input  logic [15:0]      cfg_prd,
  input  logic [15:0]      cfg_con,
  input  logic [7:0]       cfg_rpt,
  input  logic [TMO_W-1:0] cfg_tmo,
  input  logic             tmr_int,
  output logic             tmr_cnt_wr,
  output logic             tmr_prd_wr,
  output logic             tmr_con_wr,
  output logic [15:0]      icb_wdat,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [7:0]       evt_cnt
);

  localparam logic [15:0] CLR_MASK = 16'(1) << INT_CLR_BIT;
  localparam logic [3:0]  GAP_LAST = 4'(WR_GAP - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_CNT, S_GAP_PRD, S_WR_PRD, S_GAP_CON, S_WR_CON, S_RUN, S_ACK, S_DIS
  } state_t;

  state_t           state;
  logic [15:0]      sh_prd, sh_con;
  logic [7:0]       sh_rpt;
  logic [TMO_W-1:0] sh_tmo, tmo_cnt, tmo_nxt;
  logic [3:0]       gap_cnt;
  logic             tmr_int_q;
  logic             evt, last_evt, tmo_hit, abort;
  logic [7:0]       evt_inc;

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    evt      = tmr_int & ~tmr_int_q;
    evt_inc  = (evt_cnt == 8'hFF) ? evt_cnt : evt_cnt + 8'd1;
    last_evt = (sh_rpt != 8'd0) && (evt_inc == sh_rpt);
    tmo_nxt  = tmo_cnt + TMO_W'(1);
    tmo_hit  = (sh_tmo != '0) && (tmo_nxt == sh_tmo);
    abort    = stop && (state != S_IDLE) && (state != S_DIS);
  end

  // NOTE: all state updates are non-blocking so every register sees pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      sh_prd     <= '0;
      sh_con     <= '0;
      sh_rpt     <= '0;
      sh_tmo     <= '0;
      tmo_cnt    <= '0;
      gap_cnt    <= '0;
      tmr_int_q  <= 1'b0;
      tmr_cnt_wr <= 1'b0;
      tmr_prd_wr <= 1'b0;
      tmr_con_wr <= 1'b0;
      icb_wdat   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      evt_cnt    <= '0;
    end else begin
      tmr_cnt_wr <= 1'b0;
      tmr_prd_wr <= 1'b0;
      tmr_con_wr <= 1'b0;
      done       <= 1'b0;
      tmr_int_q  <= tmr_int;

      if (abort) begin
        // An event coinciding with stop is still counted; stop decides the path.
        if (state == S_RUN && evt) evt_cnt <= evt_inc;
        state      <= S_DIS;
        tmr_con_wr <= 1'b1;
        icb_wdat   <= CLR_MASK;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            sh_prd     <= cfg_prd;
            sh_con     <= cfg_con;
            sh_rpt     <= cfg_rpt;
            sh_tmo     <= cfg_tmo;
            evt_cnt    <= '0;
            err        <= 1'b0;
            busy       <= 1'b1;
            state      <= S_WR_CNT;
            tmr_cnt_wr <= 1'b1;
            icb_wdat   <= cfg_cnt;
          end
          S_WR_CNT: begin
            if (WR_GAP == 0) begin
              state      <= S_WR_PRD;
              tmr_prd_wr <= 1'b1;
              icb_wdat   <= sh_prd;
            end else begin
              state   <= S_GAP_PRD;
              gap_cnt <= GAP_LAST;
            end
          end
          S_GAP_PRD: begin
            if (gap_cnt == 4'd0) begin
              state      <= S_WR_PRD;
              tmr_prd_wr <= 1'b1;
              icb_wdat   <= sh_prd;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
          S_WR_PRD: begin
            if (WR_GAP == 0) begin
              state      <= S_WR_CON;
              tmr_con_wr <= 1'b1;
              icb_wdat   <= sh_con;
            end else begin
              state   <= S_GAP_CON;
              gap_cnt <= GAP_LAST;
            end
          end
          S_GAP_CON: begin
            if (gap_cnt == 4'd0) begin
              state      <= S_WR_CON;
              tmr_con_wr <= 1'b1;
              icb_wdat   <= sh_con;
            end else begin
              gap_cnt <= gap_cnt - 4'd1;
            end
          end
          S_WR_CON: begin
            state   <= S_RUN;
            tmo_cnt <= '0;
          end
          S_RUN: begin
            if (evt) begin
              evt_cnt    <= evt_inc;
              tmo_cnt    <= '0;
              tmr_con_wr <= 1'b1;
              if (last_evt) begin
                state    <= S_DIS;
                done     <= 1'b1;
                icb_wdat <= CLR_MASK;
              end else begin
                state    <= S_ACK;
                icb_wdat <= sh_con | CLR_MASK;
              end
            end else if (tmo_hit) begin
              err        <= 1'b1;
              state      <= S_DIS;
              tmr_con_wr <= 1'b1;
              icb_wdat   <= CLR_MASK;
            end else begin
              tmo_cnt <= tmo_nxt;
            end
          end
          S_ACK: begin
            state   <= S_RUN;
            tmo_cnt <= '0;
          end
          S_DIS: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_cfg_seq.sv
// Scoreboard bench for timer_cfg_seq: stimulus queues expected register writes,
// a negedge monitor pops and compares them whenever a write strobe appears.
module tb_timer_cfg_seq;

  localparam int TMO_W = 20;

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             start = 1'b0, stop = 1'b0, tmr_int = 1'b0;
  logic [15:0]      cfg_cnt = '0, cfg_prd = '0, cfg_con = '0;
  logic [7:0]       cfg_rpt = '0;
  logic [TMO_W-1:0] cfg_tmo = '0;
  logic             tmr_cnt_wr, tmr_prd_wr, tmr_con_wr;
  logic [15:0]      icb_wdat;
  logic             busy, done, err;
  logic [7:0]       evt_cnt;

  timer_cfg_seq #(.WR_GAP(2), .TMO_W(TMO_W), .INT_CLR_BIT(15)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop),
    .cfg_cnt(cfg_cnt), .cfg_prd(cfg_prd), .cfg_con(cfg_con),
    .cfg_rpt(cfg_rpt), .cfg_tmo(cfg_tmo), .tmr_int(tmr_int),
    .tmr_cnt_wr(tmr_cnt_wr), .tmr_prd_wr(tmr_prd_wr), .tmr_con_wr(tmr_con_wr),
    .icb_wdat(icb_wdat), .busy(busy), .done(done), .err(err), .evt_cnt(evt_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    int          kind;   // 0 = cnt, 1 = prd, 2 = con
    logic [15:0] data;
    int          cyc;    // -1 = any cycle
  } wr_t;

  wr_t sb[$];
  int  total = 0, bad = 0;
  int  cyc = 0;
  int  done_seen = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge sys_clk) begin
    wr_t e;
    int  n, kind;
    if (done) done_seen++;
    if (tmr_cnt_wr || tmr_prd_wr || tmr_con_wr) begin
      n = int'(tmr_cnt_wr) + int'(tmr_prd_wr) + int'(tmr_con_wr);
      check("strobe_onehot", n, 1);
      kind = tmr_cnt_wr ? 0 : (tmr_prd_wr ? 1 : 2);
      if (sb.size() == 0) begin
        check("unexpected_strobe", kind, 99);
      end else begin
        e = sb.pop_front();
        check("strobe_kind", kind, e.kind);
        check("strobe_data", {16'h0, icb_wdat}, {16'h0, e.data});
        if (e.cyc >= 0) check("strobe_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic expect_wr(input int kind, input logic [15:0] data, input int at);
    wr_t e;
    e.kind = kind; e.data = data; e.cyc = at;
    sb.push_back(e);
  endtask

  // Issues a start pulse in cycle k; returns k. Queues the programming writes.
  task automatic do_start(input logic [15:0] c, input logic [15:0] p, input logic [15:0] n,
                          input logic [7:0] r, input int t, input bit full, output int k);
    @(negedge sys_clk);
    k = cyc;
    expect_wr(0, c, k + 1);
    if (full) begin
      expect_wr(1, p, k + 4);
      expect_wr(2, n, k + 7);
    end
    cfg_cnt = c; cfg_prd = p; cfg_con = n; cfg_rpt = r; cfg_tmo = TMO_W'(t);
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic pulse_int(input int hi);
    @(negedge sys_clk);
    tmr_int = 1'b1;
    repeat (hi) @(negedge sys_clk);
    tmr_int = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget && busy; i++) @(negedge sys_clk);
    check("idle_within_budget", {31'b0, busy}, 0);
  endtask

  initial begin
    int k, d0;
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, d0;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_evt_cnt", {24'b0, evt_cnt}, 0);
    check("rst_wdat", {16'b0, icb_wdat}, 0);
    check("rst_strobes", {29'b0, tmr_cnt_wr, tmr_prd_wr, tmr_con_wr}, 0);

    // 1: single event completion
    d0 = done_seen;
    do_start(16'h0000, 16'h0020, 16'h0001, 8'd1, 0, 1'b1, k);
    repeat (10) @(negedge sys_clk);
    check("t1_busy_run", {31'b0, busy}, 1);
    expect_wr(2, 16'h8000, -1);
    pulse_int(2);
    wait_idle(20);
    check("t1_evt_cnt", {24'b0, evt_cnt}, 1);
    check("t1_done", done_seen - d0, 1);
    check("t1_err", {31'b0, err}, 0);

    // 2: three events, two ACKs
    d0 = done_seen;
    do_start(16'h0100, 16'h0040, 16'h0001, 8'd3, 0, 1'b1, k);
    repeat (10) @(negedge sys_clk);
    expect_wr(2, 16'h8001, -1);
    expect_wr(2, 16'h8001, -1);
    expect_wr(2, 16'h8000, -1);
    pulse_int(2);
    check("t2_evt_mid", {24'b0, evt_cnt}, 1);
    check("t2_done_mid", done_seen - d0, 0);
    pulse_int(2);
    pulse_int(2);
    wait_idle(20);
    check("t2_evt_cnt", {24'b0, evt_cnt}, 3);
    check("t2_done", done_seen - d0, 1);

    // 3: timeout after 50 RUN cycles
    d0 = done_seen;
    do_start(16'h0002, 16'h0003, 16'h0004, 8'd0, 50, 1'b1, k);
    expect_wr(2, 16'h8000, k + 58);
    wait_idle(100);
    check("t3_err", {31'b0, err}, 1);
    check("t3_done", done_seen - d0, 0);

    // 4: stop during the first gap; start also clears err
    d0 = done_seen;
    do_start(16'h1234, 16'h5678, 16'h9ABC, 8'd0, 0, 1'b0, k);
    check("t4_err_cleared", {31'b0, err}, 0);
    @(negedge sys_clk);
    expect_wr(2, 16'h8000, k + 3);
    stop = 1'b1;
    @(negedge sys_clk);
    stop = 1'b0;
    wait_idle(10);
    check("t4_done", done_seen - d0, 0);
    check("t4_err", {31'b0, err}, 0);
    check("t4_wdat_hold", {16'b0, icb_wdat}, 32'h8000);

    // 5: level interrupt counts once; start while busy ignored
    do_start(16'h0011, 16'h0022, 16'h0003, 8'd0, 0, 1'b1, k);
    repeat (10) @(negedge sys_clk);
    expect_wr(2, 16'h8003, -1);
    tmr_int = 1'b1;
    repeat (5) @(negedge sys_clk);
    cfg_cnt = 16'hDEAD; cfg_prd = 16'hBEEF; cfg_con = 16'h0070; cfg_rpt = 8'd1;
    start = 1'b1;
    @(negedge sys_clk);
    start = 1'b0;
    repeat (14) @(negedge sys_clk);
    tmr_int = 1'b0;
    @(negedge sys_clk);
    check("t5_single_evt", {24'b0, evt_cnt}, 1);
    expect_wr(2, 16'h8003, -1);
    pulse_int(2);
    check("t5_second_evt", {24'b0, evt_cnt}, 2);
    check("t5_busy", {31'b0, busy}, 1);
    expect_wr(2, 16'h8000, -1);
    @(negedge sys_clk);
    stop = 1'b1;
    @(negedge sys_clk);
    stop = 1'b0;
    wait_idle(10);

    // 6: asynchronous reset in RUN, then a clean run
    do_start(16'h0007, 16'h0008, 16'h0005, 8'd0, 0, 1'b1, k);
    repeat (10) @(negedge sys_clk);
    expect_wr(2, 16'h8005, -1);
    pulse_int(2);
    #2;
    sys_rst = 1'b1;
    #1;
    check("t6_rst_busy", {31'b0, busy}, 0);
    check("t6_rst_evt", {24'b0, evt_cnt}, 0);
    check("t6_rst_wdat", {16'b0, icb_wdat}, 0);
    @(negedge sys_clk);
    sys_rst = 1'b0;
    d0 = done_seen;
    do_start(16'h00AA, 16'h00BB, 16'h0001, 8'd1, 0, 1'b1, k);
    repeat (10) @(negedge sys_clk);
    expect_wr(2, 16'h8000, -1);
    pulse_int(2);
    wait_idle(20);
    check("t6_evt_cnt", {24'b0, evt_cnt}, 1);
    check("t6_done", done_seen - d0, 1);

    repeat (5) @(negedge sys_clk);
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
